// File: rtl/fetch_source_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the reset PC / bubble
// instruction that decode and exception logic also rely on.
package fetch_source_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int          DEF_PC_WIDTH   = 32;
  localparam int          DEF_INST_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h1c00_0000;
  localparam logic [31:0] DEF_NOP_INST   = 32'h0340_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;

endpackage : fetch_source_pkg

// File: rtl/fetch_source_if.sv
// Instruction-bus (req/addr_ok/data_ok) and first-stage (valid/allow) signals
// seen by the fetch unit; master = fetch side, slave = memory + downstream side.
interface fetch_source_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);

  logic                           inst_req;
  logic [PC_WIDTH-1:0]            inst_addr;
  logic                           inst_addr_ok;
  logic                           inst_data_ok;
  logic [INST_WIDTH-1:0]          inst_rdata;
  logic                           valid_out;
  logic [PC_WIDTH+INST_WIDTH-1:0] data_out;
  logic                           allow_in;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata,
    output valid_out,
    output data_out,
    input  allow_in
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata,
    input  valid_out,
    input  data_out,
    output allow_in
  );

endinterface : fetch_source_if

// File: rtl/fetch_source.sv
// Pipeline head: single-outstanding instruction fetch with an inline one-entry
// output buffer and downstream redirect/flush handling.
module fetch_source
  import fetch_source_pkg::*;
#(
  parameter int                    PC_WIDTH   = DEF_PC_WIDTH,
  parameter int                    INST_WIDTH = DEF_INST_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
  parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(DEF_NOP_INST)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  fetch_source_if.master      bus
);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  cancel_q, cancel_d;

  logic                  inst_req_c;
  logic                  valid_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      cancel_q <= cancel_d;
    end
  end

  // Redirect is checked first in every state so it outranks addr_ok, data_ok and allow_in.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    cancel_d   = cancel_q;
    inst_req_c = 1'b0;
    valid_c    = 1'b0;

    unique case (state_q)
      S_REQ: begin
        inst_req_c = !redirect_valid;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (bus.inst_addr_ok) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.inst_data_ok) begin
          if (cancel_q || redirect_valid) begin
            cancel_d = 1'b0;
            state_d  = S_REQ;
            if (redirect_valid) begin
              pc_d = redirect_pc;
            end
          end else begin
            inst_d  = bus.inst_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          // The response is still owed by the bus; remember to swallow it.
          pc_d     = redirect_pc;
          cancel_d = 1'b1;
        end
      end

      S_HOLD: begin
        valid_c = !redirect_valid;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          inst_d  = NOP_INST;
          state_d = S_REQ;
        end else if (bus.allow_in) begin
          pc_d    = pc_q + PC_WIDTH'(PC_STEP);
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Outputs are masked while reset is held so nothing leaks from pre-reset state.
  assign bus.inst_req  = inst_req_c & ~reset;
  assign bus.inst_addr = pc_q;
  assign bus.valid_out = valid_c & ~reset;
  assign bus.data_out  = bus.valid_out ? {pc_q, inst_q} : {pc_q, NOP_INST};

  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.valid_out && !bus.allow_in) |=>
      (redirect_valid || (bus.valid_out && $stable(bus.data_out))));

  a_no_req_while_valid: assert property (@(posedge clk) disable iff (reset)
    !(bus.inst_req && bus.valid_out));

  a_legal_state: assert property (@(posedge clk) disable iff (reset)
    state_q inside {S_REQ, S_WAIT, S_HOLD});

endmodule : fetch_source

// File: tb/tb_fetch_source.sv
// Directed bench for fetch_source: a latency-programmable bus responder plus a
// scoreboard monitor that checks every accepted request and every transfer.
module tb_fetch_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        addr_ok_en = 1'b0;
  int          data_lat = 1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int xfer_cnt = 0;
  int xfer_cyc [0:15];
  int rel_cyc = 0;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_data_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fetch_source_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus_if ();

  assign bus_if.inst_addr_ok = bus_if.inst_req & addr_ok_en;

  fetch_source dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Bus responder: data_ok arrives data_lat cycles after the accept cycle;
  // rdata is the request address with its halves swapped.
  initial begin
    logic        acc_s, rst_s, pending;
    logic [31:0] addr_s, paddr;
    int          cnt;
    bus_if.inst_data_ok = 1'b0;
    bus_if.inst_rdata   = 32'h0;
    acc_s = 1'b0; rst_s = 1'b0; pending = 1'b0;
    addr_s = 32'h0; paddr = 32'h0; cnt = 0;
    forever begin
      @(negedge clk);
      acc_s  = bus_if.inst_req & bus_if.inst_addr_ok;
      addr_s = bus_if.inst_addr;
      rst_s  = reset;
      @(posedge clk);
      #1;
      if (rst_s) begin
        pending = 1'b0;
        bus_if.inst_data_ok = 1'b0;
      end else begin
        if (bus_if.inst_data_ok) begin
          bus_if.inst_data_ok = 1'b0;
          pending = 1'b0;
        end
        if (acc_s) begin
          pending = 1'b1;
          paddr   = addr_s;
          cnt     = data_lat - 1;
        end
        if (pending) begin
          if (cnt == 0) begin
            bus_if.inst_data_ok = 1'b1;
            bus_if.inst_rdata   = {paddr[15:0], paddr[31:16]};
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.inst_req === 1'b1 && bus_if.inst_addr_ok === 1'b1) begin
        acc_cnt++;
        $display("req   cyc=%0d addr=%h", cyc, bus_if.inst_addr);
        if (exp_addr_q.size() == 0)
          check("unexpected_req", 64'(bus_if.inst_addr), 64'hffff_ffff_ffff_ffff);
        else
          check("req_addr", 64'(bus_if.inst_addr), 64'(exp_addr_q.pop_front()));
      end
      if (bus_if.valid_out === 1'b1 && bus_if.allow_in === 1'b1) begin
        if (xfer_cnt < 16) xfer_cyc[xfer_cnt] = cyc;
        xfer_cnt++;
        $display("xfer  cyc=%0d pc=%h inst=%h", cyc, bus_if.data_out[63:32], bus_if.data_out[31:0]);
        if (exp_data_q.size() == 0)
          check("unexpected_xfer", bus_if.data_out, 64'hffff_ffff_ffff_ffff);
        else
          check("xfer_data", bus_if.data_out, exp_data_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_xfers(input int n);
    int t = 0;
    while (xfer_cnt < n && t < 60) begin
      tick();
      t++;
    end
    check("xfer_count", 64'(xfer_cnt), 64'(n));
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 60) begin
      tick();
      t++;
    end
    check("acc_count", 64'(acc_cnt), 64'(n));
  endtask

  task automatic wait_valid();
    int t = 0;
    while (bus_if.valid_out !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    check("valid_arrives", 64'(bus_if.valid_out), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) xfer_cyc[i] = -1;
    bus_if.allow_in = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_valid", 64'(bus_if.valid_out), 64'(0));
    check("rst_req", 64'(bus_if.inst_req), 64'(0));
    check("rst_data", bus_if.data_out, {32'h1c000000, 32'h03400000});
    tick();

    // 1) Sequential fetch, addr_ok immediate, data_ok +1
    reset = 1'b0;
    rel_cyc = cyc;
    data_lat = 1;
    bus_if.allow_in = 1'b1;
    addr_ok_en = 1'b1;
    exp_addr_q.push_back(32'h1c000000);
    exp_addr_q.push_back(32'h1c000004);
    exp_addr_q.push_back(32'h1c000008);
    exp_data_q.push_back({32'h1c000000, 32'h00001c00});
    exp_data_q.push_back({32'h1c000004, 32'h00041c00});
    exp_data_q.push_back({32'h1c000008, 32'h00081c00});
    @(negedge clk);
    check("first_req", 64'(bus_if.inst_req), 64'(1));
    check("first_addr", 64'(bus_if.inst_addr), 64'(32'h1c000000));
    wait_xfers(3);
    addr_ok_en = 1'b0;
    check("lat_xfer0", 64'(xfer_cyc[0]), 64'(rel_cyc + 2));
    check("lat_xfer1", 64'(xfer_cyc[1]), 64'(rel_cyc + 5));
    check("lat_xfer2", 64'(xfer_cyc[2]), 64'(rel_cyc + 8));

    // 2) Stall in S_HOLD for 5 cycles
    exp_addr_q.push_back(32'h1c00000c);
    exp_data_q.push_back({32'h1c00000c, 32'h000c1c00});
    bus_if.allow_in = 1'b0;
    addr_ok_en = 1'b1;
    wait_valid();
    addr_ok_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus_if.valid_out), 64'(1));
      check("stall_data", bus_if.data_out, {32'h1c00000c, 32'h000c1c00});
      check("stall_noreq", 64'(bus_if.inst_req), 64'(0));
      tick();
    end
    bus_if.allow_in = 1'b1;
    wait_xfers(4);

    // 3) Redirect in S_WAIT, response two cycles later is discarded
    exp_addr_q.push_back(32'h1c000010);
    data_lat = 3;
    addr_ok_en = 1'b1;
    wait_acc(5);
    addr_ok_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000100;
    @(negedge clk);
    check("wait_redir_noreq", 64'(bus_if.inst_req), 64'(0));
    tick();
    redirect_valid = 1'b0;
    exp_addr_q.push_back(32'h1c000100);
    exp_data_q.push_back({32'h1c000100, 32'h01001c00});
    data_lat = 1;
    addr_ok_en = 1'b1;
    wait_xfers(5);
    addr_ok_en = 1'b0;

    // 4) Redirect in the same cycle as data_ok
    exp_addr_q.push_back(32'h1c000104);
    data_lat = 2;
    addr_ok_en = 1'b1;
    wait_acc(7);
    addr_ok_en = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000200;
    @(negedge clk);
    check("dataok_redir_dok", 64'(bus_if.inst_data_ok), 64'(1));
    check("dataok_redir_valid", 64'(bus_if.valid_out), 64'(0));
    tick();
    redirect_valid = 1'b0;
    exp_addr_q.push_back(32'h1c000200);
    exp_data_q.push_back({32'h1c000200, 32'h02001c00});
    data_lat = 1;
    addr_ok_en = 1'b1;
    wait_xfers(6);
    addr_ok_en = 1'b0;

    // 5) Redirect in S_HOLD with allow_in=1: no transfer
    exp_addr_q.push_back(32'h1c000204);
    bus_if.allow_in = 1'b0;
    addr_ok_en = 1'b1;
    wait_valid();
    addr_ok_en = 1'b0;
    bus_if.allow_in = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1c000300;
    @(negedge clk);
    check("hold_redir_valid", 64'(bus_if.valid_out), 64'(0));
    check("hold_redir_data", bus_if.data_out, {32'h1c000204, 32'h03400000});
    tick();
    redirect_valid = 1'b0;
    exp_addr_q.push_back(32'h1c000300);
    exp_data_q.push_back({32'h1c000300, 32'h03001c00});
    addr_ok_en = 1'b1;
    wait_xfers(7);
    addr_ok_en = 1'b0;

    // 6a) PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hfffffffc;
    @(negedge clk);
    check("req_redir_noreq", 64'(bus_if.inst_req), 64'(0));
    tick();
    redirect_valid = 1'b0;
    exp_addr_q.push_back(32'hfffffffc);
    exp_addr_q.push_back(32'h00000000);
    exp_data_q.push_back({32'hfffffffc, 32'hfffcffff});
    exp_data_q.push_back({32'h00000000, 32'h00000000});
    addr_ok_en = 1'b1;
    wait_xfers(9);
    addr_ok_en = 1'b0;

    // 6b) Reset while holding valid data
    exp_addr_q.push_back(32'h00000004);
    bus_if.allow_in = 1'b0;
    addr_ok_en = 1'b1;
    wait_valid();
    addr_ok_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("hold_rst_valid", 64'(bus_if.valid_out), 64'(0));
    check("hold_rst_req", 64'(bus_if.inst_req), 64'(0));
    tick();
    reset = 1'b0;
    exp_addr_q.push_back(32'h1c000000);
    exp_data_q.push_back({32'h1c000000, 32'h00001c00});
    bus_if.allow_in = 1'b1;
    addr_ok_en = 1'b1;
    @(negedge clk);
    check("post_rst_req", 64'(bus_if.inst_req), 64'(1));
    check("post_rst_addr", 64'(bus_if.inst_addr), 64'(32'h1c000000));
    wait_xfers(10);
    addr_ok_en = 1'b0;

    tick();
    tick();
    check("addr_q_empty", 64'(exp_addr_q.size()), 64'(0));
    check("data_q_empty", 64'(exp_data_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_source
